dir_request_arbiter: RTL and testbench

DIR_REQUEST_ARBITER -- requirements
Module: dir_request_arbiter

---
 rtl/input_pkg.sv | 20 ++
 rtl/key_pulse.sv | 36 +++
 rtl/dir_request_arbiter.sv | 103 ++++++++++
 tb/tb_dir_request_arbiter.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/input_pkg.sv
// Shared types for the direction-input path: direction encoding and
// the one-shot key filter state.
package input_pkg;

  localparam int NUM_DIRS = 4;

  typedef enum logic [1:0] {
    UP    = 2'd0,
    DOWN  = 2'd1,
    LEFT  = 2'd2,
    RIGHT = 2'd3
  } dir_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PULSE = 2'd1,
    HOLD  = 2'd2
  } pulse_state_t;

endpackage

// File: rtl/key_pulse.sv
// One-shot filter: turns a synchronous button level into a single-cycle
// pulse per press, regardless of how long the button is held.
module key_pulse
  import input_pkg::*;
(
  input  logic CLOCK_50,
  input  logic reset_n,
  input  logic in,
  output logic out
);

  pulse_state_t state_reg, state_next;

  always_ff @(posedge CLOCK_50 or negedge reset_n) begin
    if (!reset_n) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = IDLE;
    out        = 1'b0;
    case (state_reg)
      IDLE:    if (in) state_next = PULSE;
      PULSE: begin
        out = 1'b1;
        if (in) state_next = HOLD;
      end
      HOLD:    if (in) state_next = HOLD;
      default: state_next = IDLE;
    endcase
  end

endmodule

// File: rtl/dir_request_arbiter.sv
// Collects one-shot key presses into per-direction pending bits, grants them
// round-robin into a small direction FIFO feeding the movement engine.
module dir_request_arbiter
  import input_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic       CLOCK_50,
  input  logic       reset_n,
  input  logic       key_up,
  input  logic       key_down,
  input  logic       key_left,
  input  logic       key_right,
  input  logic       move_ready,
  output logic       dir_valid,
  output logic [1:0] dir,
  output logic       overflow
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  logic [NUM_DIRS-1:0] key_vec, pulse_vec;
  logic [NUM_DIRS-1:0] pending_reg, pending_next, grant_vec;
  dir_t                rr_ptr_reg, rr_ptr_next, grant_dir, cand;
  logic                grant_any, pop, can_accept;
  logic                overflow_reg, overflow_next;
  logic [PW-1:0]       rd_ptr_reg, wr_ptr_reg;
  logic [CW-1:0]       count_reg;
  dir_t                fifo_mem [DEPTH];

  assign key_vec = {key_right, key_left, key_down, key_up};

  for (genvar gi = 0; gi < NUM_DIRS; gi++) begin : g_filter
    key_pulse u_key_pulse (
      .CLOCK_50 (CLOCK_50),
      .reset_n  (reset_n),
      .in       (key_vec[gi]),
      .out      (pulse_vec[gi])
    );
  end

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  assign dir_valid  = (count_reg != '0);
  assign dir        = fifo_mem[rd_ptr_reg];
  assign overflow   = overflow_reg;
  assign pop        = dir_valid && move_ready;
  assign can_accept = (count_reg < CW'(DEPTH)) || pop;

  // Round-robin search over the registered pending bits, starting at rr_ptr.
  always_comb begin
    grant_any = 1'b0;
    grant_dir = rr_ptr_reg;
    cand      = rr_ptr_reg;
    for (int k = 0; k < NUM_DIRS; k++) begin
      cand = dir_t'(rr_ptr_reg + 2'(k));
      if (!grant_any && can_accept && pending_reg[cand]) begin
        grant_any = 1'b1;
        grant_dir = cand;
      end
    end
    grant_vec = '0;
    if (grant_any) grant_vec[grant_dir] = 1'b1;
    // A fresh pulse re-arms a direction granted in the same cycle without loss.
    pending_next  = (pending_reg & ~grant_vec) | pulse_vec;
    overflow_next = overflow_reg | (|(pulse_vec & pending_reg & ~grant_vec));
    rr_ptr_next   = grant_any ? dir_t'(grant_dir + 2'd1) : rr_ptr_reg;
  end

  always_ff @(posedge CLOCK_50 or negedge reset_n) begin
    if (!reset_n) begin
      pending_reg  <= '0;
      rr_ptr_reg   <= UP;
      overflow_reg <= 1'b0;
      rd_ptr_reg   <= '0;
      wr_ptr_reg   <= '0;
      count_reg    <= '0;
    end else begin
      pending_reg  <= pending_next;
      rr_ptr_reg   <= rr_ptr_next;
      overflow_reg <= overflow_next;
      if (grant_any) wr_ptr_reg <= ptr_inc(wr_ptr_reg);
      if (pop)       rd_ptr_reg <= ptr_inc(rd_ptr_reg);
      case ({grant_any, pop})
        2'b10:   count_reg <= count_reg + CW'(1);
        2'b01:   count_reg <= count_reg - CW'(1);
        default: count_reg <= count_reg;
      endcase
    end
  end

  always_ff @(posedge CLOCK_50 or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < DEPTH; i++) fifo_mem[i] <= UP;
    end else if (grant_any) begin
      fifo_mem[wr_ptr_reg] <= grant_dir;
    end
  end

endmodule

// File: tb/tb_dir_request_arbiter.sv
// Randomized and directed checks of dir_request_arbiter against a queue-based
// reference model of presses, pending requests and the direction FIFO.
module tb_dir_request_arbiter;

  localparam int DEPTH = 2;

  logic       CLOCK_50 = 1'b0;
  logic       reset_n = 1'b0;
  logic       move_ready = 1'b0;
  logic [3:0] keys = 4'b0000;
  logic       dir_valid, overflow;
  logic [1:0] dir;

  always #5 CLOCK_50 = ~CLOCK_50;

  dir_request_arbiter #(.DEPTH(DEPTH)) dut (
    .CLOCK_50   (CLOCK_50),
    .reset_n    (reset_n),
    .key_up     (keys[0]),
    .key_down   (keys[1]),
    .key_left   (keys[2]),
    .key_right  (keys[3]),
    .move_ready (move_ready),
    .dir_valid  (dir_valid),
    .dir        (dir),
    .overflow   (overflow)
  );

  int n_cmp = 0;
  int n_fail = 0;

  // Reference model: a press is a low-to-high change of the sampled key level.
  int       mq[$];
  bit [3:0] m_pend, m_pulse, m_prev;
  int       m_rr;
  bit       m_ovf;

  task automatic model_reset();
    mq.delete();
    m_pend = '0; m_pulse = '0; m_prev = '0; m_rr = 0; m_ovf = 1'b0;
  endtask

  task automatic model_edge();
    bit pop, can;
    int win;
    pop = (mq.size() != 0) && move_ready;
    can = (mq.size() < DEPTH) || pop;
    win = -1;
    if (can) begin
      for (int k = 0; k < 4; k++) begin
        int c = (m_rr + k) % 4;
        if (win < 0 && m_pend[c]) win = c;
      end
    end
    if (pop) void'(mq.pop_front());
    if (win >= 0) begin
      mq.push_back(win);
      m_pend[win] = 1'b0;
      m_rr = (win + 1) % 4;
    end
    if ((m_pulse & m_pend) != 0) m_ovf = 1'b1;
    m_pend  = m_pend | m_pulse;
    m_pulse = keys & ~m_prev;
    m_prev  = keys;
  endtask

  task automatic tick();
    @(posedge CLOCK_50);
    model_edge();
    #1;
  endtask

  task automatic assert_reset();
    #3;
    reset_n = 1'b0;
    model_reset();
  endtask

  task automatic release_reset();
    @(posedge CLOCK_50);
    @(posedge CLOCK_50);
    #4;
    reset_n = 1'b1;
  endtask

  task automatic test_reset();
    model_reset();
    #1;
    n_cmp++; if (dir_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b expected 0", dir_valid); end
    n_cmp++; if (dir !== 2'd0) begin n_fail++; $display("FAIL reset_dir: got %0d expected 0", dir); end
    n_cmp++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL reset_ovf: got %b expected 0", overflow); end
    #3;
    reset_n = 1'b1;
    $display("test_reset done");
  endtask

  task automatic test_hold_left();
    int vcnt = 0;
    int first = -1;
    assert_reset(); release_reset();
    move_ready = 1'b1;
    for (int e = 0; e < 15; e++) begin
      keys = (e < 10) ? 4'b0100 : 4'b0000;
      tick();
      n_cmp++; if (dir_valid !== 1'(mq.size() != 0)) begin n_fail++; $display("FAIL hold_left_valid e=%0d: got %b expected %b", e, dir_valid, mq.size() != 0); end
      if (dir_valid) begin
        vcnt++;
        if (first < 0) first = e;
        n_cmp++; if (dir !== 2'd2) begin n_fail++; $display("FAIL hold_left_dir: got %0d expected 2", dir); end
      end
    end
    n_cmp++; if (vcnt != 1) begin n_fail++; $display("FAIL hold_left_count: got %0d expected 1", vcnt); end
    n_cmp++; if (first != 2) begin n_fail++; $display("FAIL hold_left_latency: got edge %0d expected 2", first); end
    $display("test_hold_left: valid cycles=%0d first edge=%0d", vcnt, first);
  endtask

  task automatic test_all_four();
    int got[$];
    assert_reset(); release_reset();
    move_ready = 1'b0;
    keys = 4'b1111; tick();
    keys = 4'b0000;
    for (int i = 0; i < 5; i++) tick();
    n_cmp++; if (dir_valid !== 1'b1 || dir !== 2'd0) begin n_fail++; $display("FAIL all4_head: got v=%b d=%0d expected v=1 d=0", dir_valid, dir); end
    n_cmp++; if (mq.size() != 2 || m_pend != 4'b1100) begin n_fail++; $display("FAIL all4_model_state: got q=%0d pend=%b expected q=2 pend=1100", mq.size(), m_pend); end
    move_ready = 1'b1;
    for (int i = 0; i < 20 && got.size() < 4; i++) begin
      if (dir_valid) got.push_back(int'(dir));
      tick();
      n_cmp++; if (dir_valid !== 1'(mq.size() != 0)) begin n_fail++; $display("FAIL all4_valid: got %b expected %b", dir_valid, mq.size() != 0); end
    end
    n_cmp++; if (got.size() != 4) begin n_fail++; $display("FAIL all4_count: got %0d expected 4", got.size()); end
    for (int i = 0; i < got.size(); i++) begin
      n_cmp++; if (got[i] != i) begin n_fail++; $display("FAIL all4_order[%0d]: got %0d expected %0d", i, got[i], i); end
    end
    n_cmp++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL all4_ovf: got %b expected 0", overflow); end
    $display("test_all_four: delivered %0d directions", got.size());
  endtask

  task automatic test_overflow();
    assert_reset(); release_reset();
    move_ready = 1'b0;
    keys = 4'b0011; tick();
    keys = 4'b0000; repeat (4) tick();
    keys = 4'b0001; tick();
    keys = 4'b0000; repeat (2) tick();
    n_cmp++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL ovf_before: got %b expected 0", overflow); end
    keys = 4'b0001; tick();
    keys = 4'b0000; repeat (2) tick();
    n_cmp++; if (overflow !== 1'b1) begin n_fail++; $display("FAIL ovf_set: got %b expected 1", overflow); end
    for (int i = 0; i < 10; i++) begin
      move_ready = 1'($urandom_range(0, 1));
      keys = 4'($urandom);
      tick();
      n_cmp++; if (overflow !== 1'b1 || m_ovf !== 1'b1) begin n_fail++; $display("FAIL ovf_sticky: got %b expected 1", overflow); end
    end
    keys = 4'b0000;
    assert_reset();
    #1;
    n_cmp++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL ovf_reset: got %b expected 0", overflow); end
    release_reset();
    $display("test_overflow done");
  endtask

  task automatic test_stall();
    logic [1:0] d0;
    assert_reset(); release_reset();
    move_ready = 1'b0;
    keys = 4'b1100; tick();
    keys = 4'b0000; repeat (3) tick();
    d0 = dir;
    n_cmp++; if (dir_valid !== 1'b1 || d0 !== 2'd2) begin n_fail++; $display("FAIL stall_head: got v=%b d=%0d expected v=1 d=2", dir_valid, d0); end
    for (int i = 0; i < 5; i++) begin
      tick();
      n_cmp++; if (dir !== d0 || dir_valid !== 1'b1) begin n_fail++; $display("FAIL stall_hold: got v=%b d=%0d expected v=1 d=%0d", dir_valid, dir, d0); end
    end
    move_ready = 1'b1;
    tick();
    n_cmp++; if (dir_valid !== 1'b1 || dir !== 2'd3) begin n_fail++; $display("FAIL stall_pop1: got v=%b d=%0d expected v=1 d=3", dir_valid, dir); end
    tick();
    n_cmp++; if (dir_valid !== 1'b0) begin n_fail++; $display("FAIL stall_pop2: got v=%b expected 0", dir_valid); end
    $display("test_stall done");
  endtask

  task automatic test_async_reset();
    assert_reset(); release_reset();
    move_ready = 1'b0;
    keys = 4'b0011; tick();
    keys = 4'b0000; repeat (4) tick();
    keys = 4'b0100; tick();
    keys = 4'b0000; repeat (2) tick();
    n_cmp++; if (dir_valid !== 1'b1 || mq.size() != 2 || m_pend != 4'b0100) begin n_fail++; $display("FAIL arst_setup: got v=%b q=%0d expected v=1 q=2", dir_valid, mq.size()); end
    assert_reset();
    #1;
    n_cmp++; if (dir_valid !== 1'b0 || dir !== 2'd0) begin n_fail++; $display("FAIL arst_immediate: got v=%b d=%0d expected v=0 d=0", dir_valid, dir); end
    release_reset();
    move_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      n_cmp++; if (dir_valid !== 1'b0) begin n_fail++; $display("FAIL arst_after: got v=%b expected 0", dir_valid); end
    end
    $display("test_async_reset done");
  endtask

  task automatic test_key_held_reset();
    int nright = 0;
    int nvalid = 0;
    keys = 4'b1000;
    assert_reset(); release_reset();
    move_ready = 1'b1;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (dir_valid) begin
        nvalid++;
        if (dir == 2'd3) nright++;
      end
    end
    keys = 4'b0000;
    tick();
    n_cmp++; if (nvalid != 1 || nright != 1) begin n_fail++; $display("FAIL held_reset: got valid=%0d right=%0d expected 1/1", nvalid, nright); end
    $display("test_key_held_reset: valid=%0d right=%0d", nvalid, nright);
  endtask

  task automatic test_random();
    for (int blk = 0; blk < 4; blk++) begin
      keys = 4'b0000;
      assert_reset(); release_reset();
      for (int i = 0; i < 100; i++) begin
        for (int b = 0; b < 4; b++) if ($urandom_range(0, 3) == 0) keys[b] = ~keys[b];
        move_ready = ($urandom_range(0, 2) != 0);
        tick();
        n_cmp++; if (dir_valid !== 1'(mq.size() != 0)) begin n_fail++; $display("FAIL rnd_valid blk=%0d i=%0d: got %b expected %b", blk, i, dir_valid, mq.size() != 0); end
        if (mq.size() != 0) begin
          n_cmp++; if (int'(dir) != mq[0]) begin n_fail++; $display("FAIL rnd_dir blk=%0d i=%0d: got %0d expected %0d", blk, i, dir, mq[0]); end
        end
        n_cmp++; if (overflow !== m_ovf) begin n_fail++; $display("FAIL rnd_ovf blk=%0d i=%0d: got %b expected %b", blk, i, overflow, m_ovf); end
      end
      $display("test_random block %0d done", blk);
    end
    keys = 4'b0000;
  endtask

  initial begin
    test_reset();
    test_hold_left();
    test_all_four();
    test_overflow();
    test_stall();
    test_async_reset();
    test_key_held_reset();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
